// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Shared definitions for the HDB3 encoder chain.
//   - Input symbol codes produced by the B-insertion stage.
//   - Line codes driven towards the line interface.
//   - Polarity type used to remember the sign of the last pulse.
//   - Small helpers that map a polarity onto a line code.

package hdb3_pkg;

  // Symbols arriving from the B-insertion stage
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  // Signed line codes; 2'b10 is never produced
  localparam logic [1:0] LINE_ZERO = 2'b00;
  localparam logic [1:0] LINE_POS  = 2'b01;
  localparam logic [1:0] LINE_NEG  = 2'b11;

  // Encoded so that a 1-bit INIT_POS parameter casts directly onto it
  typedef enum logic {
    POL_NEG = 1'b0,
    POL_POS = 1'b1
  } pol_t;

  function automatic pol_t pol_flip(input pol_t p);
    return (p == POL_POS) ? POL_NEG : POL_POS;
  endfunction

  function automatic logic [1:0] pol_to_line(input pol_t p);
    return (p == POL_POS) ? LINE_POS : LINE_NEG;
  endfunction

endpackage

// File: rtl/hdb3_rds_mon.sv
// hdb3_rds_mon
// Running-digital-sum monitor for the HDB3 line output.
// Accumulates +1 for every positive pulse and -1 for every negative pulse,
// saturating at the signed limits of an RDS_W-bit counter, and flags when
// the magnitude of the sum exceeds RDS_LIMIT.
//
// Ports:
//   clk        input   clock, rising edge
//   rst_n      input   asynchronous active-low reset
//   pos_pulse  input   a positive pulse is being registered on the line this edge
//   neg_pulse  input   a negative pulse is being registered on the line this edge
//   dc_err     output  registered, high while |rds| > RDS_LIMIT
//
// The counter is updated on the same edge as the line output it accounts
// for, so dc_err lines up with the pulse that pushes the sum over the limit.

module hdb3_rds_mon #(
  parameter int RDS_W     = 4,
  parameter int RDS_LIMIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pos_pulse,
  input  logic neg_pulse,
  output logic dc_err
);

  localparam int RDS_MAX = (2 ** (RDS_W - 1)) - 1;
  localparam int RDS_MIN = -(2 ** (RDS_W - 1));

  logic signed [RDS_W-1:0] rds;
  logic signed [RDS_W-1:0] rds_next;
  logic                    dc_err_next;
  int                      sum;
  int                      mag;

  // Work in a wide integer so the saturation compare and the magnitude of
  // the most negative value cannot overflow.
  always_comb begin
    sum = int'(rds);
    if (pos_pulse) begin
      sum = sum + 1;
    end else if (neg_pulse) begin
      sum = sum - 1;
    end
    if (sum > RDS_MAX) begin
      sum = RDS_MAX;
    end else if (sum < RDS_MIN) begin
      sum = RDS_MIN;
    end
    mag         = (sum < 0) ? -sum : sum;
    rds_next    = sum[RDS_W-1:0];
    dc_err_next = (mag > RDS_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rds    <= '0;
      dc_err <= 1'b0;
    end else begin
      rds    <= rds_next;
      dc_err <= dc_err_next;
    end
  end

endmodule

// File: rtl/hdb3_polarity.sv
// hdb3_polarity
// Final stage of the HDB3 encoder: assigns line polarity to each symbol
// coming out of the B-insertion stage.
//   - marks and B pulses alternate (AMI);
//   - V pulses repeat the polarity of the previous pulse;
//   - successive V pulses are checked for alternation.
//
// Ports:
//   clk          input   clock, rising edge
//   rst_n        input   asynchronous active-low reset
//   data_plug_b  input   [1:0] 00 zero, 01 mark, 11 V, 10 B
//   data_hdb3    output  [1:0] 00 zero, 01 positive, 11 negative
//   hdb3_p       output  positive rail
//   hdb3_n       output  negative rail
//   v_err        output  one-cycle pulse when a V repeats the previous V polarity
//   dc_err       output  only with HDB3_DC_MON_EN: |running digital sum| > RDS_LIMIT
//
// Build option: define HDB3_DC_MON_EN to add the running-digital-sum
// monitor (hdb3_rds_mon) and the dc_err port.
//
// All outputs are registered; a symbol sampled on edge n is visible on the
// outputs right after edge n.

module hdb3_polarity
  import hdb3_pkg::*;
#(
  parameter bit INIT_POS  = 1'b0,
  parameter int RDS_W     = 4,
  parameter int RDS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] data_plug_b,
  output logic [1:0] data_hdb3,
  output logic       hdb3_p,
  output logic       hdb3_n,
  output logic       v_err
`ifdef HDB3_DC_MON_EN
  ,
  output logic       dc_err
`endif
);

  // Polarity of the last emitted pulse; this is the two-state FSM
  pol_t       last_pol;
  pol_t       last_pol_next;

  // V alternation history
  logic       v_seen;
  logic       v_seen_next;
  pol_t       last_v_pol;
  pol_t       last_v_pol_next;

  logic [1:0] line_next;
  logic       v_err_next;

  // Next-state and next-output decode for one input symbol
  always_comb begin
    last_pol_next   = last_pol;
    v_seen_next     = v_seen;
    last_v_pol_next = last_v_pol;
    line_next       = LINE_ZERO;
    v_err_next      = 1'b0;
    case (data_plug_b)
      SYM_ONE, SYM_B: begin
        last_pol_next = pol_flip(last_pol);
        line_next     = pol_to_line(pol_flip(last_pol));
      end
      SYM_V: begin
        // A V repeats the last pulse polarity and must oppose the previous V
        line_next       = pol_to_line(last_pol);
        v_err_next      = v_seen && (last_pol == last_v_pol);
        last_v_pol_next = last_pol;
        v_seen_next     = 1'b1;
      end
      default: begin
        line_next = LINE_ZERO;
      end
    endcase
  end

  // State and output registers; reset drops all polarity history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pol   <= pol_t'(INIT_POS);
      v_seen     <= 1'b0;
      last_v_pol <= POL_NEG;
      data_hdb3  <= LINE_ZERO;
      hdb3_p     <= 1'b0;
      hdb3_n     <= 1'b0;
      v_err      <= 1'b0;
    end else begin
      last_pol   <= last_pol_next;
      v_seen     <= v_seen_next;
      last_v_pol <= last_v_pol_next;
      data_hdb3  <= line_next;
      hdb3_p     <= (line_next == LINE_POS);
      hdb3_n     <= (line_next == LINE_NEG);
      v_err      <= v_err_next;
    end
  end

`ifdef HDB3_DC_MON_EN
  hdb3_rds_mon #(
    .RDS_W     (RDS_W),
    .RDS_LIMIT (RDS_LIMIT)
  ) u_rds_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_pulse (line_next == LINE_POS),
    .neg_pulse (line_next == LINE_NEG),
    .dc_err    (dc_err)
  );
`else
  // The DC monitor parameters only matter when the monitor is built
  logic unused_rds_cfg;
  assign unused_rds_cfg = ^{RDS_W[0], RDS_LIMIT[0]};
`endif

endmodule

// File: doc/hdb3_polarity.md
Name: hdb3_polarity

Overview:
- Final stage of the HDB3 encoder chain; sits directly downstream of the B-insertion stage and consumes its 2-bit symbol stream.
- Assigns line polarity to every pulse symbol:
  - marks and B pulses follow AMI alternation;
  - V pulses repeat the polarity of the preceding pulse.
- Emits the result as a 2-bit signed code and as separate P/N rails for the line driver.
- Monitors the alternation of successive V pulses and flags any breach of the HDB3 rule.

Parameters:
- INIT_POS, 0: polarity treated as "last pulse" after reset. 0 = last was negative, so the first mark goes positive. 1 = the opposite.
- RDS_W, 4: width of the signed running-digital-sum counter. Used only with HDB3_DC_MON_EN.
- RDS_LIMIT, 2: magnitude of the running digital sum above which dc_err asserts. Used only with HDB3_DC_MON_EN.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- data_plug_b  input  2  symbol from the B-insertion stage: 00 zero, 01 mark, 11 V, 10 B
- data_hdb3  output  2  coded line symbol: 00 zero, 01 positive pulse, 11 negative pulse (10 never driven)
- hdb3_p  output  1  positive rail, 1 when data_hdb3 == 01
- hdb3_n  output  1  negative rail, 1 when data_hdb3 == 11
- v_err  output  1  one-cycle pulse; a V has the same polarity as the previous V
- dc_err  output  1  only present with HDB3_DC_MON_EN; |RDS| > RDS_LIMIT

Behaviour:
- Reset, asynchronous on rst_n low:
  - outputs: data_hdb3 = 00, hdb3_p = 0, hdb3_n = 0, v_err = 0, dc_err = 0;
  - last_pol = INIT_POS; v_seen = 0; last_v_pol = 0; rds = 0.
- Reset mid-stream discards all polarity history. The first pulse after release follows INIT_POS.
- Polarity FSM, two states (LAST_POS, LAST_NEG) held in last_pol. Per input symbol, registered:
  - 00: output 00, state unchanged.
  - 01 or 10: output pulse of polarity opposite to last_pol; state toggles.
  - 11: output pulse of polarity equal to last_pol; state unchanged.
- Latency: exactly 1 clk, input sampled at edge n appears on outputs after edge n.
- The input is a continuous stream with no handshake; every cycle carries one symbol.
- hdb3_p and hdb3_n are registered together with data_hdb3. They are never both 1.
- V check:
  - On each V, compare its output polarity with last_v_pol.
  - If v_seen = 1 and the two are equal, pulse v_err for one cycle, aligned with that V on data_hdb3.
  - Then update last_v_pol and set v_seen = 1.
  - The first V after reset never flags.
- Under a correct upstream, v_err stays 0. Encoding continues unchanged after an error; v_err is not sticky.

Optional Feature:
- Macro HDB3_DC_MON_EN.
- Defined:
  - signed rds register, RDS_W bits; +1 per positive output, -1 per negative output, updated in the same cycle as the output;
  - rds saturates at the RDS_W signed limits and never wraps;
  - dc_err is registered high while |rds| > RDS_LIMIT;
  - rds and dc_err are cleared by reset.
- Undefined:
  - the dc_err port and the rds logic are absent;
  - RDS_W and RDS_LIMIT are unused.

Decomposition:
- Shared package hdb3_pkg holds:
  - symbol constants SYM_ZERO = 2'b00, SYM_ONE = 2'b01, SYM_B = 2'b10, SYM_V = 2'b11;
  - line codes LINE_ZERO = 2'b00, LINE_POS = 2'b01, LINE_NEG = 2'b11;
  - polarity enum POL_POS / POL_NEG.
- Natural sub-module: hdb3_rds_mon, containing the running-sum counter, saturation and limit compare. It is instantiated only under HDB3_DC_MON_EN.

Test Plan:
- Reset, then input 01,01,01,01 → data_hdb3 01,11,01,11 one cycle later; hdb3_p/hdb3_n mirror; v_err = 0.
- Input 01,00,00,00,11 → outputs 01,00,00,00,01 (V repeats +); state stays LAST_POS; next 01 → 11.
- Input 01,11,00,00,10,00,00,11 → 01,01,00,00,11,00,00,11; V polarities alternate (+,−); v_err = 0.
- Illegal sequence 01,11,01,01,11 → V polarities +,+ → v_err pulses exactly on the second V output cycle.
- Assert rst_n low asynchronously mid-pulse → outputs drop to 00 immediately; after release, 01 → 01 (INIT_POS = 0).
- With HDB3_DC_MON_EN and RDS_LIMIT = 2, drive the illegal stream 11,11,11 after an initial 01 → rds reaches 4; dc_err high from the cycle rds becomes 3; rds saturates at 7 under continued V.
